// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory stream loader: the frame
// parser state encoding, the default frame start marker and the constant
// byte-enable pattern driven on the memory port.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [3:0] BYTEENABLE_ALL    = 4'hF;

endpackage

// File: rtl/imem_loader_packer.sv
// imem_loader_packer
// Packs accepted stream bytes little-endian into 32-bit words.
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   clear       - restart packing at byte 0 (start of a new frame)
//   byte_valid  - byte_data is accepted this cycle
//   byte_data   - stream byte
//   byte_idx    - position (0..3) the next accepted byte takes in the word
//   word_valid  - one-cycle strobe, asserted the cycle after the 4th byte
//   word        - completed word, held until the next word completes
module imem_loader_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word
);

    // Low three bytes of the word being assembled; the 4th byte goes
    // straight into the output register so the next word can start
    // assembling while the previous one is being written.
    logic [23:0] asm_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx   <= 2'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= 2'd0;
            end else if (byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    word       <= {byte_data, asm_p0};
                    word_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (byte_valid) begin
            case (byte_idx)
                2'd0:    asm_p0[7:0]   <= byte_data;
                2'd1:    asm_p0[15:8]  <= byte_data;
                2'd2:    asm_p0[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// imem_stream_loader
// Receives a framed byte stream (SYNC, LEN_LO, LEN_HI, LEN*4 data bytes,
// CHK) and writes the packed words into instruction memory from word 0,
// holding the CPU in reset while a load is in flight.
// Ports:
//   clk, reset           - single clock, synchronous active-high reset
//   in_data/in_valid     - byte stream input
//   in_ready             - byte accepted when in_valid & in_ready
//   address, byteenable, chipselect, write, writedata, clken
//                        - Avalon-style write master to memory port s2
//   cpu_reset_req        - hold the processor in reset
//   busy                 - a frame is being parsed
//   done / error         - one-cycle result pulses
//   words_written        - words written by the last/current frame
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 13,
    parameter int         DEPTH     = 4134,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              clken,
    output logic              cpu_reset_req,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_written
);

    state_t            state, state_next;
    logic              hs, sync_hs, data_hs, word_end, word_last;
    logic              len_bad, chk_ok;
    logic [15:0]       len_next;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       word_cnt;
    logic [7:0]        chk_sum;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_idx;
    logic              word_valid;
    logic [31:0]       word;

    assign hs        = in_valid & in_ready;
    assign sync_hs   = hs & (state == IDLE) & (in_data == SYNC_BYTE);
    assign data_hs   = hs & (state == DATA);
    assign word_end  = data_hs & (byte_idx == 2'd3);
    // word_cnt counts completed words before this one, so the frame's
    // last word ends when it equals LEN-1 (LEN is at least 1 in DATA).
    assign word_last = word_end & (word_cnt == len - 16'd1);
    assign len_next  = {in_data, len_lo};
    assign len_bad   = (len_next == 16'd0) || (len_next > 16'(DEPTH));
    assign chk_ok    = (in_data == chk_sum);

    imem_loader_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (sync_hs),
        .byte_valid (data_hs),
        .byte_data  (in_data),
        .byte_idx   (byte_idx),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sync_hs) state_next = LEN0;
            LEN0:    if (hs) state_next = LEN1;
            LEN1:    if (hs) state_next = len_bad ? ERR : DATA;
            DATA:    if (word_last) state_next = CHK;
            CHK:     if (hs) state_next = chk_ok ? DONE : ERR;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            LEN0, LEN1, DATA, CHK: busy = 1'b1;
            DONE: begin
                in_ready = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                in_ready = 1'b0;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    // Control counters and CPU hold
    always_ff @(posedge clk) begin
        if (reset) begin
            addr          <= '0;
            words_written <= 16'd0;
            word_cnt      <= 16'd0;
            cpu_reset_req <= 1'b0;
        end else begin
            if (sync_hs) begin
                addr          <= '0;
                words_written <= 16'd0;
            end else if (word_valid) begin
                addr          <= addr + ADDR_W'(1);
                words_written <= words_written + 16'd1;
            end

            if (sync_hs)       word_cnt <= 16'd0;
            else if (word_end) word_cnt <= word_cnt + 16'd1;

            // Released only by a verified image; an error leaves it held.
            if (sync_hs)                              cpu_reset_req <= 1'b1;
            else if ((state == CHK) && hs && chk_ok) cpu_reset_req <= 1'b0;
        end
    end

    // Frame header and checksum capture
    always_ff @(posedge clk) begin
        if (hs && (state == LEN0)) len_lo <= in_data;
        if (hs && (state == LEN1)) len    <= len_next;
        if (sync_hs)               chk_sum <= 8'd0;
        else if (data_hs)          chk_sum <= chk_sum + in_data;
    end

    assign address    = addr;
    assign byteenable = BYTEENABLE_ALL;
    assign chipselect = word_valid;
    assign write      = word_valid;
    assign writedata  = word;
    assign clken      = 1'b1;

endmodule

// File: tb/tb_imem_stream_loader.sv
module tb_imem_stream_loader;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 4134;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              clken;
    logic              cpu_reset_req;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       words_written;

    always #5 clk = ~clk;

    imem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .write         (write),
        .writedata     (writedata),
        .clken         (clken),
        .cpu_reset_req (cpu_reset_req),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          rdy;
        bit          wr;
        logic [12:0] a;
        logic [31:0] wd;
        bit          bsy;
        bit          dn;
        bit          er;
        bit          crr;
        logic [15:0] ww;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input logic [7:0] d, input bit rdy, input bit wr,
                       input logic [12:0] a, input logic [31:0] wd, input bit bsy,
                       input bit dn, input bit er, input bit crr, input logic [15:0] ww);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.wr = wr; r.a = a; r.wd = wd;
        r.bsy = bsy; r.dn = dn; r.er = er; r.crr = crr; r.ww = ww;
        tbl.push_back(r);
    endtask

    // ---------------- write monitor ----------------
    bit          mon_en = 1'b0;
    bit          tag4 = 1'b0;   // the byte on in_data is the 4th of a word
    bit          pend4 = 1'b0;  // a 4th byte was handshaken at the last edge
    logic [12:0] wq_a[$];
    logic [31:0] wq_d[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (write || pend4) begin
                check("write_timing", write, pend4);
                check("chipselect_timing", chipselect, pend4);
            end
            if (write) begin
                wq_a.push_back(address);
                wq_d.push_back(writedata);
            end
            pend4 = in_valid && in_ready && tag4;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] dbyte(input int k);
        return 8'((k * 37 + 5) ^ (k >> 8));
    endfunction

    function automatic logic [31:0] dword(input int w);
        return {dbyte(4*w+3), dbyte(4*w+2), dbyte(4*w+1), dbyte(4*w)};
    endfunction

    function automatic int rgap(input int gapmax);
        if (gapmax == 0) return 0;
        return int'($urandom_range(0, gapmax));
    endfunction

    task automatic send(input logic [7:0] d, input bit t4, input int gap);
        repeat (gap) begin
            @(posedge clk); #1 in_valid = 1'b0; tag4 = 1'b0;
        end
        @(posedge clk); #1 in_valid = 1'b1; in_data = d; tag4 = t4;
        @(negedge clk);
        for (int g = 0; g < 50 && !in_ready; g++) @(negedge clk);
        if (!in_ready) check("send_ready_timeout", in_ready, 1);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1 in_valid = 1'b0; tag4 = 1'b0;
        @(negedge clk);
    endtask

    // Ends at the negedge right after the CHK (or LEN_HI) handshake edge.
    task automatic send_frame(input int len, input int nwords, input bit bad, input int gapmax);
        logic [7:0]  sum;
        logic [15:0] l;
        sum = 8'd0;
        l = 16'(len);
        send(8'hA5, 1'b0, 0);
        send(l[7:0], 1'b0, rgap(gapmax));
        send(l[15:8], 1'b0, rgap(gapmax));
        for (int k = 0; k < 4 * nwords; k++) begin
            send(dbyte(k), (k % 4) == 3, rgap(gapmax));
            sum = sum + dbyte(k);
        end
        if (nwords > 0) send(sum + 8'(bad), 1'b0, rgap(gapmax));
        idle_cycle();
    endtask

    task automatic expect_end(input string name, input bit dn, input bit er);
        check({name, "_done"}, done, dn);
        check({name, "_error"}, error, er);
        check({name, "_in_ready"}, in_ready, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic check_writes(input string name, input int n);
        check({name, "_nwrites"}, wq_a.size(), n);
        for (int i = 0; i < wq_a.size() && i < n; i++) begin
            check($sformatf("%s_addr%0d", name, i), wq_a[i], i);
            check($sformatf("%s_data%0d", name, i), wq_d[i], dword(i));
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_in_ready"}, in_ready, 1);
        check({name, "_write"}, write, 0);
        check({name, "_chipselect"}, chipselect, 0);
        check({name, "_address"}, address, 0);
        check({name, "_writedata"}, writedata, 0);
        check({name, "_byteenable"}, byteenable, 4'hF);
        check({name, "_clken"}, clken, 1);
        check({name, "_cpu_reset_req"}, cpu_reset_req, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_error"}, error, 0);
        check({name, "_words_written"}, words_written, 0);
    endtask

    logic [12:0] g_a[$];
    logic [31:0] g_d[$];

    initial begin
        // Good frame: 2 words, CHK 0x64.
        add(1, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h02, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h11, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h22, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h33, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h44, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h55, 1, 1, 0, 32'h44332211, 1, 0, 0, 1, 0);
        add(1, 8'h66, 1, 0, 0, 0, 1, 0, 0, 1, 1);
        add(1, 8'h77, 1, 0, 0, 0, 1, 0, 0, 1, 1);
        add(1, 8'h88, 1, 0, 0, 0, 1, 0, 0, 1, 1);
        add(1, 8'h64, 1, 1, 1, 32'h88776655, 1, 0, 0, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        // Same frame, bad CHK 0x65.
        add(1, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, 8'h02, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h11, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h22, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h33, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h44, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h55, 1, 1, 0, 32'h44332211, 1, 0, 0, 1, 0);
        add(1, 8'h66, 1, 0, 0, 0, 1, 0, 0, 1, 1);
        add(1, 8'h77, 1, 0, 0, 0, 1, 0, 0, 1, 1);
        add(1, 8'h88, 1, 0, 0, 0, 1, 0, 0, 1, 1);
        add(1, 8'h65, 1, 1, 1, 32'h88776655, 1, 0, 0, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 2);
        // LEN = 0: error right after LEN_HI.
        add(1, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 1, 2);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        // Garbage before SYNC, then a 1-word frame (checksum 0x0A).
        add(1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h5A, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h02, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h03, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h04, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(1, 8'h0A, 1, 1, 0, 32'h04030201, 1, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("in_reset");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("after_reset");

        // Table: inputs drive the next edge, outputs observed before it.
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1 in_valid = tbl[i].v; in_data = tbl[i].d;
            @(negedge clk);
            check($sformatf("r%0d_in_ready", i), in_ready, tbl[i].rdy);
            check($sformatf("r%0d_write", i), write, tbl[i].wr);
            check($sformatf("r%0d_chipselect", i), chipselect, tbl[i].wr);
            if (tbl[i].wr) begin
                check($sformatf("r%0d_address", i), address, tbl[i].a);
                check($sformatf("r%0d_writedata", i), writedata, tbl[i].wd);
            end
            check($sformatf("r%0d_busy", i), busy, tbl[i].bsy);
            check($sformatf("r%0d_done", i), done, tbl[i].dn);
            check($sformatf("r%0d_error", i), error, tbl[i].er);
            check($sformatf("r%0d_cpu_reset_req", i), cpu_reset_req, tbl[i].crr);
            check($sformatf("r%0d_words_written", i), words_written, tbl[i].ww);
        end

        mon_en = 1'b1;

        // LEN = 4135: one past the memory, rejected after LEN_HI.
        wq_a.delete(); wq_d.delete();
        send(8'hA5, 1'b0, 0);
        send(8'h27, 1'b0, 0);
        send(8'h10, 1'b0, 0);
        idle_cycle();
        expect_end("len4135", 0, 1);
        check("len4135_cpu_reset_req", cpu_reset_req, 1);
        repeat (4) idle_cycle();
        check("len4135_nwrites", wq_a.size(), 0);

        // LEN = DEPTH: fills the whole memory.
        wq_a.delete(); wq_d.delete();
        send_frame(DEPTH, DEPTH, 1'b0, 0);
        expect_end("len4134", 1, 0);
        check("len4134_cpu_reset_req", cpu_reset_req, 0);
        check("len4134_words_written", words_written, DEPTH);
        check_writes("len4134", DEPTH);
        if (wq_a.size() > 0) check("len4134_last_addr", wq_a[wq_a.size()-1], 4133);

        // Reset after 5 data bytes of a 2-word frame.
        wq_a.delete(); wq_d.delete();
        send(8'hA5, 1'b0, 0);
        send(8'h02, 1'b0, 0);
        send(8'h00, 1'b0, 0);
        for (int k = 0; k < 5; k++) send(dbyte(k), (k % 4) == 3, 0);
        @(posedge clk); #1 in_valid = 1'b0; tag4 = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        check_writes("midreset_partial", 1);
        wq_a.delete(); wq_d.delete();
        send_frame(2, 2, 1'b0, 0);
        expect_end("reload", 1, 0);
        check("reload_words_written", words_written, 2);
        check("reload_cpu_reset_req", cpu_reset_req, 0);
        check_writes("reload", 2);

        // 16 words gapless, then with random in_valid gaps.
        wq_a.delete(); wq_d.delete();
        send_frame(16, 16, 1'b0, 0);
        expect_end("nogap", 1, 0);
        check_writes("nogap", 16);
        g_a = wq_a; g_d = wq_d;
        wq_a.delete(); wq_d.delete();
        send_frame(16, 16, 1'b0, 5);
        expect_end("gap", 1, 0);
        check("gap_words_written", words_written, 16);
        check_writes("gap", 16);
        check("gap_vs_nogap_count", wq_a.size(), g_a.size());
        for (int i = 0; i < wq_a.size() && i < g_a.size(); i++) begin
            check($sformatf("gap_vs_nogap_addr%0d", i), wq_a[i], g_a[i]);
            check($sformatf("gap_vs_nogap_data%0d", i), wq_d[i], g_d[i]);
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
